// File: rtl/fir_polyphase_pkg.sv
// Shared sizing helpers for the polyphase FIR: tap count, accumulator width, field offsets.
package fir_polyphase_pkg;

  function automatic int ntaps_f(input int order);
    return order + 1;
  endfunction

  // Exact growth bound: every product plus log2 of the number of terms summed.
  function automatic int acc_width_f(input int data_w, input int coef_w,
                                     input int ntaps, input int phases);
    return data_w + coef_w + $clog2(ntaps * phases);
  endfunction

  function automatic int coef_lsb(input int coef_w, input int ntaps,
                                  input int phase, input int tap);
    return coef_w * (phase * ntaps + tap);
  endfunction

  function automatic int delay_lsb(input int delay_w, input int phase);
    return delay_w * (phase - 1);
  endfunction

  function automatic int delay_flat_w(input int delay_w, input int phases);
    return (phases > 1) ? delay_w * (phases - 1) : 1;
  endfunction

endpackage

// File: rtl/fir_polyphase_branch.sv
// One FIR branch: picks NTAPS consecutive history samples starting at the clamped delay
// and registers their MAC one cycle after the history update; no backpressure.
module fir_polyphase_branch
  import fir_polyphase_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 32,
  parameter int NTAPS       = 4,
  parameter int DELAY_WIDTH = 16,
  parameter int MAX_DELAY   = 16,
  parameter int HIST_DEPTH  = MAX_DELAY + NTAPS,
  parameter int ACC_WIDTH   = DATA_WIDTH + COEF_WIDTH + $clog2(NTAPS)
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [HIST_DEPTH*DATA_WIDTH-1:0] hist_i,
  input  logic [DELAY_WIDTH-1:0]        delay_i,
  input  logic [COEF_WIDTH*NTAPS-1:0]   coef_i,
  output logic signed [ACC_WIDTH-1:0]   mac_o
);

  localparam int SEL_W = $clog2(HIST_DEPTH);

  logic signed [DATA_WIDTH-1:0]            win [HIST_DEPTH];
  logic [SEL_W-1:0]                        dsel;
  logic [SEL_W-1:0]                        tidx;
  logic signed [DATA_WIDTH-1:0]            samp;
  logic signed [COEF_WIDTH-1:0]            cf;
  logic signed [DATA_WIDTH+COEF_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]             mac_d, mac_q;

  always_comb begin
    for (int j = 0; j < HIST_DEPTH; j++) begin
      win[j] = hist_i[DATA_WIDTH*j +: DATA_WIDTH];
    end
  end

  // Oversized delays saturate at the deepest history slot rather than wrapping.
  always_comb begin
    if (delay_i > DELAY_WIDTH'(MAX_DELAY)) dsel = SEL_W'(MAX_DELAY);
    else                                   dsel = SEL_W'(delay_i);
  end

  always_comb begin
    mac_d = '0;
    tidx  = '0;
    samp  = '0;
    cf    = '0;
    prod  = '0;
    for (int k = 0; k < NTAPS; k++) begin
      tidx  = dsel + SEL_W'(k);
      samp  = win[tidx];
      cf    = coef_i[coef_lsb(COEF_WIDTH, NTAPS, 0, k) +: COEF_WIDTH];
      prod  = samp * cf;
      mac_d = mac_d + ACC_WIDTH'(prod);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) mac_q <= '0;
    else          mac_q <= mac_d;
  end

  assign mac_o = mac_q;

endmodule

// File: rtl/fir_polyphase.sv
// Polyphase integer FIR: shared sample history, per-branch delayed MACs summed to one stream.
// Two-cycle latency (history reg, branch MAC regs); always ready, downstream must take every output.
module fir_polyphase
  import fir_polyphase_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEF_WIDTH  = 32,
  parameter int ORDER       = 3,
  parameter int PHASES      = 2,
  parameter int DELAY_WIDTH = 16,
  parameter int MAX_DELAY   = 16,
  parameter int OUT_SHIFT   = 0
) (
  input  logic                                        aclk,
  input  logic                                        aresetn,
  input  logic [DATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic                                        s_axis_tvalid,
  input  logic [COEF_WIDTH*(ORDER+1)*PHASES-1:0]      coef_flat,
  input  logic [delay_flat_w(DELAY_WIDTH, PHASES)-1:0] delay_flat,
  output logic                                        m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]                       m_axis_tdata
);

  localparam int NTAPS      = ntaps_f(ORDER);
  localparam int ACC_WIDTH  = acc_width_f(DATA_WIDTH, COEF_WIDTH, NTAPS, PHASES);
  localparam int HIST_DEPTH = MAX_DELAY + NTAPS;

  logic [HIST_DEPTH*DATA_WIDTH-1:0] hist_d, hist_q;
  logic [1:0]                       vld_d, vld_q;
  logic signed [ACC_WIDTH-1:0]      br_acc [PHASES];
  logic signed [ACC_WIDTH-1:0]      acc_sum;

  // Slot 0 holds the newest accepted sample; idle cycles leave the history untouched.
  always_comb begin
    hist_d = hist_q;
    if (s_axis_tvalid) hist_d = {hist_q[(HIST_DEPTH-1)*DATA_WIDTH-1:0], s_axis_tdata};
    vld_d = {vld_q[0], s_axis_tvalid};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hist_q <= '0;
      vld_q  <= '0;
    end else begin
      hist_q <= hist_d;
      vld_q  <= vld_d;
    end
  end

  for (genvar p = 0; p < PHASES; p++) begin : g_br
    logic [DELAY_WIDTH-1:0] dly;
    if (p == 0) begin : g_d0
      assign dly = '0;
    end else begin : g_dn
      assign dly = delay_flat[delay_lsb(DELAY_WIDTH, p) +: DELAY_WIDTH];
    end

    fir_polyphase_branch #(
      .DATA_WIDTH (DATA_WIDTH),
      .COEF_WIDTH (COEF_WIDTH),
      .NTAPS      (NTAPS),
      .DELAY_WIDTH(DELAY_WIDTH),
      .MAX_DELAY  (MAX_DELAY),
      .HIST_DEPTH (HIST_DEPTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_branch (
      .aclk   (aclk),
      .aresetn(aresetn),
      .hist_i (hist_q),
      .delay_i(dly),
      .coef_i (coef_flat[coef_lsb(COEF_WIDTH, NTAPS, p, 0) +: COEF_WIDTH*NTAPS]),
      .mac_o  (br_acc[p])
    );
  end

  // Output is a pure function of registered branch MACs, so it clears with reset.
  always_comb begin
    acc_sum = '0;
    for (int p = 0; p < PHASES; p++) acc_sum = acc_sum + br_acc[p];
  end

  assign m_axis_tdata  = DATA_WIDTH'(acc_sum >>> OUT_SHIFT);
  assign m_axis_tvalid = vld_q[1];

endmodule

// File: tb/tb_fir_polyphase.sv
// Randomized and directed bench for fir_polyphase against a sample-list reference model.
module tb_fir_polyphase;
  localparam int DW = 16, CW = 32, NT = 4, PH = 2, DLW = 16, MAXD = 16;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic [DW-1:0]        s_tdata;
  logic                 s_tvalid;
  logic [CW*NT*PH-1:0]  coef_flat;
  logic [DLW*(PH-1)-1:0] delay_flat;
  logic                 m_tvalid0, m_tvalid8;
  logic [DW-1:0]        m_tdata0, m_tdata8;

  logic [CW-1:0]  cf [PH][NT];
  logic [DLW-1:0] dly;

  int       xs[$];
  logic     prev_vld;
  int       checks = 0;
  int       errors = 0;
  string    tname;
  logic [DW-1:0] last0, last8;
  logic     lastv;
  int       tbl [24];

  always #5 aclk = ~aclk;

  for (genvar p = 0; p < PH; p++) begin : g_cf
    for (genvar k = 0; k < NT; k++) begin : g_k
      assign coef_flat[CW*(p*NT+k) +: CW] = cf[p][k];
    end
  end
  assign delay_flat = dly;

  fir_polyphase #(.OUT_SHIFT(0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .coef_flat(coef_flat), .delay_flat(delay_flat),
    .m_axis_tvalid(m_tvalid0), .m_axis_tdata(m_tdata0));

  fir_polyphase #(.OUT_SHIFT(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .coef_flat(coef_flat), .delay_flat(delay_flat),
    .m_axis_tvalid(m_tvalid8), .m_axis_tdata(m_tdata8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // y[n] = sum_p sum_k c[p][k] * x[n - d_p - k], newest accepted sample at xs[0].
  function automatic longint model_acc();
    longint acc = 0;
    for (int p = 0; p < PH; p++) begin
      int d = (p == 0) ? 0 : ((int'(dly) > MAXD) ? MAXD : int'(dly));
      for (int k = 0; k < NT; k++) begin
        int idx = d + k;
        longint x = (idx < xs.size()) ? longint'(xs[idx]) : 64'sd0;
        acc += x * longint'($signed(cf[p][k]));
      end
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] exp_dat(input int sh);
    longint a;
    a = model_acc() >>> sh;
    return a[DW-1:0];
  endfunction

  task automatic tick();
    logic [DW-1:0] e0, e8;
    logic ev, in_rst;
    e0 = exp_dat(0);
    e8 = exp_dat(8);
    ev = prev_vld;
    in_rst = !aresetn;
    if (in_rst) begin
      prev_vld = 1'b0;
      xs.delete();
    end else begin
      prev_vld = s_tvalid;
      if (s_tvalid) begin
        xs.push_front(int'($signed(s_tdata)));
        if (xs.size() > MAXD + NT) void'(xs.pop_back());
      end
    end
    @(posedge aclk);
    @(negedge aclk);
    last0 = m_tdata0;
    last8 = m_tdata8;
    lastv = m_tvalid0;
    check({tname, ".vld"}, 32'(m_tvalid0), 32'(ev));
    check({tname, ".vld8"}, 32'(m_tvalid8), 32'(ev));
    if (ev) begin
      check({tname, ".dat"}, 32'(m_tdata0), 32'(e0));
      check({tname, ".dat8"}, 32'(m_tdata8), 32'(e8));
    end else if (in_rst) begin
      check({tname, ".rstdat"}, 32'(m_tdata0), 32'd0);
    end
  endtask

  task automatic set_cfg(input logic [31:0] a0, a1, a2, a3, b0, b1, b2, b3,
                         input logic [DLW-1:0] d);
    cf[0][0] = a0; cf[0][1] = a1; cf[0][2] = a2; cf[0][3] = a3;
    cf[1][0] = b0; cf[1][1] = b1; cf[1][2] = b2; cf[1][3] = b3;
    dly = d;
  endtask

  task automatic clr_tbl();
    foreach (tbl[i]) tbl[i] = 0;
  endtask

  // tbl[m] holds the required y[n+m] after a single impulse of value v at sample n.
  task automatic impulse_table(input string nm, input logic [DW-1:0] v);
    tname = nm;
    s_tvalid = 1'b1;
    s_tdata = '0;
    repeat (24) tick();
    s_tdata = v;
    tick();
    s_tdata = '0;
    for (int i = 0; i < 24; i++) begin
      tick();
      check({nm, ".tbl"}, 32'(last0), 32'(tbl[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    logic [DW-1:0] seen[$];
    tname = "reset";
    aresetn = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = '0;
    prev_vld = 1'b0;
    set_cfg(0, 1, 16, 32'h100, 0, 0, 0, 0, 16'd5);
    #2 aresetn = 1'b0;
    #1;
    check("reset.dat", 32'(m_tdata0), 32'd0);
    check("reset.vld", 32'(m_tvalid0), 32'd0);
    repeat (20) tick();
    aresetn = 1'b1;

    clr_tbl(); tbl[1] = 1; tbl[2] = 16; tbl[3] = 256;
    impulse_table("impulse", 16'd1);

    set_cfg(0, 0, 0, 0, 1, 2, 3, 4, 16'd5);
    clr_tbl(); tbl[5] = 1; tbl[6] = 2; tbl[7] = 3; tbl[8] = 4;
    impulse_table("delayed", 16'd1);

    set_cfg(0, 1, 16, 32'h100, 1, 2, 3, 4, 16'd5);
    clr_tbl(); tbl[1] = 3; tbl[2] = 48; tbl[3] = 768;
    tbl[5] = 3; tbl[6] = 6; tbl[7] = 9; tbl[8] = 12;
    impulse_table("both", 16'd3);

    set_cfg(0, 1, 16, 32'h100, 1, 2, 3, 4, 16'd2);
    clr_tbl(); tbl[1] = 3; tbl[2] = 51; tbl[3] = 774; tbl[4] = 9; tbl[5] = 12;
    impulse_table("overlap", 16'd3);

    set_cfg(0, 0, 0, 0, 1, 2, 3, 4, 16'd100);
    clr_tbl(); tbl[16] = 1; tbl[17] = 2; tbl[18] = 3; tbl[19] = 4;
    impulse_table("clamp", 16'd1);

    tname = "gap";
    set_cfg(0, 1, 16, 32'h100, 0, 0, 0, 0, 16'd5);
    s_tdata = '0;
    repeat (24) tick();
    s_tdata = 16'd1;
    tick();
    s_tdata = '0;
    lowcnt = 0;
    for (int i = 0; i < 12; i++) begin
      s_tvalid = !(i >= 2 && i < 5);
      tick();
      if (lastv) seen.push_back(last0);
      else lowcnt++;
    end
    s_tvalid = 1'b1;
    check("gap.lowcnt", 32'(lowcnt), 32'd3);
    check("gap.y0", 32'(seen[0]), 32'd0);
    check("gap.y1", 32'(seen[1]), 32'd1);
    check("gap.y2", 32'(seen[2]), 32'd16);
    check("gap.y3", 32'(seen[3]), 32'd256);
    check("gap.y4", 32'(seen[4]), 32'd0);

    tname = "rstmid";
    repeat (24) tick();
    s_tdata = 16'd1;
    tick();
    s_tdata = '0;
    repeat (2) tick();
    aresetn = 1'b0;
    #1;
    check("rstmid.dat", 32'(m_tdata0), 32'd0);
    check("rstmid.dat8", 32'(m_tdata8), 32'd0);
    check("rstmid.vld", 32'(m_tvalid0), 32'd0);
    xs.delete();
    prev_vld = 1'b0;
    repeat (3) tick();
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rstmid.post", 32'(last0), 32'd0);
    end

    tname = "wrap";
    set_cfg(32'h10000, 0, 0, 0, 0, 0, 0, 0, 16'd5);
    repeat (24) tick();
    s_tdata = 16'd1;
    tick();
    s_tdata = '0;
    tick();
    check("wrap.trunc", 32'(last0), 32'd0);
    check("wrap.shift8", 32'(last8), 32'h100);
    repeat (4) tick();

    tname = "random";
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        for (int p = 0; p < PH; p++) begin
          logic zero_br;
          zero_br = ($urandom_range(0, 3) == 0);
          for (int k = 0; k < NT; k++) cf[p][k] = zero_br ? 32'd0 : 32'($urandom);
        end
        dly = 16'($urandom_range(0, 40));
      end
      s_tvalid = ($urandom_range(0, 9) < 8);
      s_tdata = 16'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_polyphase.md
Name: fir_polyphase

Overview:
- Multi-branch ("polyphase") integer FIR on an AXI-Stream-style sample stream. No tready.
- Branch p is a NTAPS-tap FIR fed by the input delayed by a run-time per-branch delay (branch 0 undelayed).
- All branch outputs are summed into one output stream.
- Sits in the DSP datapath between an ADC/stream source and downstream AXIS consumers. Coefficients and delays are quasi-static configuration buses.

Parameters:
- DATA_WIDTH, 16, input/output sample width (signed two's complement).
- COEF_WIDTH, 32, coefficient width (signed integer).
- ORDER, 3, filter order; NTAPS = ORDER+1 taps per branch.
- PHASES, 2, number of branches.
- DELAY_WIDTH, 16, width of each branch-delay field.
- MAX_DELAY, 16, maximum supported branch delay in samples (history depth).
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output truncation.

Ports:
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  input sample, signed.
- s_axis_tvalid  in  1  input sample valid; block is always ready.
- coef_flat  in  COEF_WIDTH*NTAPS*PHASES  coefficients; tap k of branch p = coef_flat[COEF_WIDTH*(p*NTAPS+k) +: COEF_WIDTH].
- delay_flat  in  DELAY_WIDTH*(PHASES-1)  delay of branch p (p≥1) = delay_flat[DELAY_WIDTH*(p-1) +: DELAY_WIDTH]; unsigned, in samples.
- m_axis_tvalid  out  1  output valid.
- m_axis_tdata  out  DATA_WIDTH  filtered sample, signed.

Behaviour:
- Sample history x[] is a shift register of depth MAX_DELAY+NTAPS. It advances only on cycles with s_axis_tvalid=1; otherwise contents hold.
- For accepted sample n: y[n] = Σp Σk c[p][k]·x[n−d_p−k]. Here d_0=0; d_p = min(delay_p, MAX_DELAY).
- Samples before reset release count as 0.
- Accumulator: signed, ACC_WIDTH = DATA_WIDTH+COEF_WIDTH+clog2(NTAPS*PHASES); no overflow is possible.
- m_axis_tdata = (acc >>> OUT_SHIFT)[DATA_WIDTH-1:0]. This truncates and wraps; there is no saturation.
- Pipeline:
  - Cycle 1: register the input into history.
  - Cycle 2: register products and sum into the output register.
- Latency: y[n] appears on m_axis_tdata 2 aclk cycles after the edge that accepts sample n.
- m_axis_tvalid is s_axis_tvalid delayed by exactly 2 cycles.
- No backpressure. Downstream must accept every valid output.
- Reset (aresetn=0, asynchronous): history, product and output registers are cleared. m_axis_tdata=0, m_axis_tvalid=0.
- Reset asserted mid-stream discards all history and in-flight results immediately.
- After release, the first accepted sample sees all-zero history.
- coef_flat and delay_flat are sampled combinationally every cycle. A change affects results computed from that cycle on; no glitch protection is required.
- delay > MAX_DELAY clamps to MAX_DELAY.
- Branches whose coefficients are all zero contribute exactly 0.
- PHASES=1: delay_flat is unused (declare it with width ≥1).

Decomposition:
- Package fir_polyphase_pkg: NTAPS derivation, ACC_WIDTH function (clog2-based), coef/delay field index helper functions.
- Sub-module fir_polyphase_branch, one per branch, generate-instantiated:
  - Takes the history window and its delay.
  - Selects NTAPS delayed samples and produces the registered branch MAC.
- Top level holds the history shift register, sums the branches, applies shift/truncate, and runs the valid pipeline.

Test Plan:
- Common setup (defaults):
  - tvalid=1 always.
  - coef phase0 taps k0..k3 = 0,1,16,0x100; phase1 all zero; delay=5.
  - aresetn low for 20 cycles, then data=1 for one cycle, then 0.
- Impulse: with the common setup -> outputs 0,1,16,256 on consecutive cycles starting 2 cycles after the impulse is accepted, then 0 forever.
- Delayed branch: phase0=0; phase1 taps = 1,2,3,4; delay=5; impulse -> outputs 1,2,3,4 starting 7 cycles after acceptance.
- Both branches active, both configured as above; input 3 for one sample -> outputs 0,3,48,768 then 3,6,9,12, with summation verified where the two windows overlap.
- tvalid gaps: deassert tvalid for 3 cycles mid-response -> m_axis_tvalid low for those 3 cycles (delayed by 2). Response sequence resumes unchanged and history is not advanced.
- Reset mid-stream: assert aresetn while the impulse response is in flight -> m_axis_tdata=0 and tvalid=0 immediately; after release the output stays 0 with input 0.
- Wrap/clamp:
  - coef 0x10000, input 1 -> m_axis_tdata=0 (truncation); with OUT_SHIFT=8 and coef 0x10000 -> 0x100.
  - delay=100 behaves as delay=MAX_DELAY.
